distance2pwm_bank: RTL and testbench
====================================

DISTANCE2PWM_BANK -- requirements
Module: distance2pwm_bank

Interface
REQ-001 Parameter WIDTH, default 13: width of each channel's distance word (units 10^-2 cm).
REQ-002 Parameter MAX_COUNT, default 3000: PWM period in enabled ticks, and the full-scale distance.
REQ-003 Parameter CHANNELS, default 4: number of independent PWM channels.
REQ-004 Parameter ALARM_THRESH, default 500: distance below which an ALARM-mode channel blinks.
REQ-005 Parameter BLINK_PERIODS, default 8: PWM periods per blink half-cycle.
REQ-006 Port clk, input, 1: single system clock; all state on its rising edge.
REQ-007 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 Port enable, input, 1: tick qualifier; the period counter advances only when enable=1 (tie to 1 for no division).
REQ-009 Port distance, input, CHANNELS*WIDTH: packed distances, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 Port mode, input, 2*CHANNELS: per-channel mode, channel i at bits [2i +: 2]. Encoding: 0=DIRECT, 1=INVERT, 2=ALARM, 3=OFF.
REQ-011 Port pwm_out, output, CHANNELS: registered PWM outputs.
REQ-012 Port alarm, output, CHANNELS: registered flag; high while an ALARM-mode channel is below threshold.
REQ-013 Port period_tick, output, 1: one-cycle pulse, registered, asserted the cycle after the counter wraps.

Function
REQ-014 The shared counter SHALL count 0..MAX_COUNT-1 on enabled cycles, wrap to 0, and hold when enable=0.
REQ-015 Each channel SHALL clamp distance to MAX_COUNT (d_clamp = min(distance, MAX_COUNT)); no wrap-around on over-range values.
REQ-016 Target duty SHALL be: DIRECT -> d_clamp; INVERT -> MAX_COUNT - d_clamp; OFF -> 0; ALARM -> d_clamp when not alarmed.
REQ-017 Target duty SHALL be sampled into a per-channel active-duty register only on the enabled wrap cycle (count MAX_COUNT-1 -> 0), so a period never mixes two duties.
REQ-018 pwm_out[i] SHALL equal registered (count < active_duty[i]), one clk of latency; duty 0 -> constant 0, duty MAX_COUNT -> constant 1.
REQ-019 An ALARM-mode channel with d_clamp < ALARM_THRESH, sampled at the wrap, SHALL be alarmed: alarm[i]=1, and pwm_out[i] = shared blink state (full on or full off for whole periods).
REQ-020 The blink state SHALL toggle after every BLINK_PERIODS wraps, via a shared period counter 0..BLINK_PERIODS-1.
REQ-021 A mode or distance change mid-period SHALL take effect only at the next wrap. pwm_out and alarm SHALL be unchanged until then.
REQ-022 If enable=0 indefinitely, outputs SHALL hold their current values.
REQ-023 Arithmetic SHALL use at least $clog2(MAX_COUNT+1) bits. INVERT SHALL never underflow, because it operates on d_clamp.

Reset
REQ-024 On reset_n=0, asynchronously: counter=0, blink counter=0, blink state=0, all active duties=0, pwm_out=0, alarm=0, period_tick=0.
REQ-025 After release, the first duty load SHALL occur at the first wrap. Outputs stay 0 for the first period.
REQ-026 Reset asserted mid-period SHALL abort the period immediately, with no residual pulse.

Structure
REQ-027 Package distance_pwm_pkg SHALL hold the mode enum (DIRECT, INVERT, ALARM, OFF) and a helper constant for counter width.
REQ-028 The per-channel duty mapping, active-duty register and compare SHALL be one sub-module, pwm_channel, instanced CHANNELS times by a generate loop.
REQ-029 The period counter, blink counter and period_tick SHALL be shared in the top level.

Verification (MAX_COUNT=10, CHANNELS=2, ALARM_THRESH=3, BLINK_PERIODS=2, enable=1)
REQ-030 ch0 DIRECT, distance 4 -> after the first wrap, pwm_out[0] high 4 clk and low 6 clk per period; period_tick every 10 clk.
REQ-031 ch1 INVERT, distance 4 -> 6 high / 4 low. Distance 15 (clamped) -> constant 0. DIRECT with 15 -> constant 1.
REQ-032 Change distance 4 -> 7 at count 2 -> current period keeps 4 high; the next period shows 7 high.
REQ-033 ch0 ALARM, distance 2 -> alarm[0]=1; pwm_out[0] 20 clk high then 20 clk low, repeating. Distance 5 -> alarm clears at the next wrap, then 5/5 PWM.
REQ-034 enable toggled 1-of-2 cycles, DIRECT 4 -> period of 20 clk with 8 clk high. Reset pulse at count 3 -> all outputs 0 at once, restart from count 0.

Source files
------------

// File: rtl/distance_pwm_pkg.sv
// Shared types and sizing helpers for the distance-to-PWM channel bank.
package distance_pwm_pkg;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    INVERT = 2'd1,
    ALARM  = 2'd2,
    OFF    = 2'd3
  } mode_e;

  // Bits needed to hold 0..max_count inclusive (full-scale duty must fit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(3000);

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: clamp/map distance to a duty, latch it at the period wrap,
// and compare against the shared period counter (or follow blink when alarmed).
module pwm_channel
  import distance_pwm_pkg::*;
#(
  parameter int unsigned WIDTH        = 13,
  parameter int unsigned MAX_COUNT    = 3000,
  parameter int unsigned ALARM_THRESH = 500,
  parameter int unsigned CW           = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wrap,
  input  logic [CW-1:0]    cnt,
  input  logic             blink,
  input  logic [WIDTH-1:0] distance,
  input  logic [1:0]       mode,
  output logic             pwm_out,
  output logic             alarm
);

  localparam int unsigned   EW    = (WIDTH > CW) ? WIDTH : CW;
  localparam logic [EW-1:0] MAX_E = EW'(MAX_COUNT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  logic [EW-1:0] dist_e;
  logic [CW-1:0] d_clamp;
  logic [CW-1:0] target;
  logic          hit;
  mode_e         mode_s;

  logic [CW-1:0] duty_q, duty_d;
  logic          alarm_q, alarm_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    dist_e  = EW'(distance);
    d_clamp = (dist_e > MAX_E) ? MAX_C : CW'(dist_e);
    mode_s  = mode_e'(mode);
    target  = '0;
    hit     = 1'b0;
    case (mode_s)
      DIRECT: target = d_clamp;
      INVERT: target = MAX_C - d_clamp;
      ALARM: begin
        target = d_clamp;
        hit    = 32'(d_clamp) < ALARM_THRESH;
      end
      OFF:    target = '0;
      default: target = '0;
    endcase

    // Duty and alarm only move at the wrap so a period never mixes settings.
    duty_d  = wrap ? target : duty_q;
    alarm_d = wrap ? hit    : alarm_q;
    pwm_d   = alarm_q ? blink : (cnt < duty_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q  <= '0;
      alarm_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      alarm_q <= alarm_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign alarm   = alarm_q;

endmodule

// File: rtl/distance2pwm_bank.sv
// Bank of distance-driven PWM channels sharing one period counter, blink
// generator and period tick.
module distance2pwm_bank
  import distance_pwm_pkg::*;
#(
  parameter int unsigned WIDTH         = 13,
  parameter int unsigned MAX_COUNT     = 3000,
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned ALARM_THRESH  = 500,
  parameter int unsigned BLINK_PERIODS = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] distance,
  input  logic [2*CHANNELS-1:0]     mode,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS-1:0]       alarm,
  output logic                      period_tick
);

  localparam int unsigned CW = cnt_width(MAX_COUNT);
  localparam int unsigned BW = cnt_width(BLINK_PERIODS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic          tick_q, tick_d;
  logic          wrap;

  always_comb begin
    wrap    = enable && (cnt_q == CW'(MAX_COUNT - 1));
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    tick_d  = wrap;

    if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    if (wrap) begin
      if (bcnt_q == BW'(BLINK_PERIODS - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  assign period_tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH       (WIDTH),
      .MAX_COUNT   (MAX_COUNT),
      .ALARM_THRESH(ALARM_THRESH),
      .CW          (CW)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .wrap    (wrap),
      .cnt     (cnt_q),
      .blink   (blink_q),
      .distance(distance[i*WIDTH +: WIDTH]),
      .mode    (mode[2*i +: 2]),
      .pwm_out (pwm_out[i]),
      .alarm   (alarm[i])
    );
  end

endmodule

// File: tb/tb_distance2pwm_bank.sv
// Scoreboard bench: stimulus pushes expected per-period summaries
// (length, high counts, alarm flags); a monitor closes a window at each tick.
module tb_distance2pwm_bank;
  import distance_pwm_pkg::*;

  localparam int unsigned W  = 13;
  localparam int unsigned MC = 10;
  localparam int unsigned CH = 2;
  localparam int unsigned TH = 3;
  localparam int unsigned BP = 2;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b1;
  logic            enable  = 1'b1;
  logic [CH*W-1:0] distance;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   pwm_out;
  logic [CH-1:0]   alarm;
  logic            period_tick;

  typedef struct {
    int unsigned len;
    int unsigned hi0;
    int unsigned hi1;
    logic [1:0]  alm;
  } rec_t;

  rec_t        exp_q[$];
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  bit          tog    = 1'b0;

  always #5 clk = ~clk;

  distance2pwm_bank #(
    .WIDTH        (W),
    .MAX_COUNT    (MC),
    .CHANNELS     (CH),
    .ALARM_THRESH (TH),
    .BLINK_PERIODS(BP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .distance   (distance),
    .mode       (mode),
    .pwm_out    (pwm_out),
    .alarm      (alarm),
    .period_tick(period_tick)
  );

  task automatic set_ch(input int ch, input mode_e m, input int unsigned d);
    distance[ch*W +: W] = W'(d);
    mode[2*ch +: 2]     = m;
  endtask

  task automatic push(input int unsigned len, input int unsigned hi0,
                      input int unsigned hi1, input logic [1:0] alm);
    rec_t r;
    r.len = len; r.hi0 = hi0; r.hi1 = hi1; r.alm = alm;
    exp_q.push_back(r);
  endtask

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (tog) enable = ~enable;
      if (period_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_fail++;
      $display("FAIL wait_tick: period_tick got 0 within 60 clk, want 1");
    end
  endtask

  // Monitor: one record per completed period, closed on period_tick.
  initial begin : mon
    int unsigned len, h0, h1;
    logic [1:0]  alast;
    rec_t        e;
    len = 0; h0 = 0; h1 = 0; alast = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n_vec++;
        if (pwm_out !== 2'b00 || alarm !== 2'b00 || period_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_outputs: got pwm=%b alarm=%b tick=%b, want 00 00 0",
                   pwm_out, alarm, period_tick);
        end
        len = 0; h0 = 0; h1 = 0; alast = '0;
      end else begin
        len++;
        h0 += 32'(pwm_out[0] === 1'b1);
        h1 += 32'(pwm_out[1] === 1'b1);
        if (period_tick === 1'b1) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL period_record: got len=%0d hi0=%0d hi1=%0d alm=%b, want none queued",
                     len, h0, h1, alast);
          end else begin
            e = exp_q.pop_front();
            if (e.len != len || e.hi0 != h0 || e.hi1 != h1 || e.alm !== alast) begin
              n_fail++;
              $display("FAIL period_record: got len=%0d hi0=%0d hi1=%0d alm=%b, want len=%0d hi0=%0d hi1=%0d alm=%b",
                       len, h0, h1, alast, e.len, e.hi0, e.hi1, e.alm);
            end
          end
          len = 0; h0 = 0; h1 = 0;
        end else begin
          alast = alarm;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    distance = '0;
    mode     = '0;
    set_ch(0, DIRECT, 4);
    set_ch(1, INVERT, 4);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // DIRECT 4 / INVERT 4; first period after reset is all-zero.
    push(11, 0, 0, 2'b00);
    push(10, 4, 6, 2'b00);
    push(10, 4, 6, 2'b00);
    wait_tick(); wait_tick();

    // Over-range distance clamps: DIRECT full on, INVERT full off.
    set_ch(0, DIRECT, 15);
    set_ch(1, INVERT, 15);
    push(10, 10, 0, 2'b00);
    push(10, 10, 0, 2'b00);
    wait_tick(); wait_tick();

    set_ch(0, DIRECT, 4);
    set_ch(1, OFF, 9);
    push(10, 4, 0, 2'b00);
    wait_tick();
    repeat (2) @(negedge clk);
    set_ch(0, DIRECT, 7);     // mid-period change lands next period
    push(10, 7, 0, 2'b00);
    wait_tick(); wait_tick();

    // Alarm / blink; ch1 sits exactly at the threshold (not alarmed).
    @(posedge clk); #2 reset_n = 1'b0;
    set_ch(0, ALARM, 2);
    set_ch(1, ALARM, 3);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push(11, 0,  0, 2'b00);
    push(10, 0,  3, 2'b01);
    push(10, 10, 3, 2'b01);
    push(10, 10, 3, 2'b01);
    push(10, 0,  3, 2'b01);
    repeat (4) wait_tick();
    set_ch(0, ALARM, 5);
    push(10, 5, 3, 2'b00);
    wait_tick();

    // Enable at half rate stretches the period to 20 clk.
    set_ch(0, DIRECT, 4);
    set_ch(1, OFF, 0);
    push(20, 8, 0, 2'b00);
    wait_tick();
    tog = 1'b1; enable = 1'b0;
    wait_tick();
    tog = 1'b0; enable = 1'b1;

    // Reset at count 3 while ch0 is high.
    repeat (3) @(negedge clk);
    n_vec++;
    if (pwm_out !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_reset_pwm: got %b, want 01", pwm_out);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (pwm_out !== 2'b00 || alarm !== 2'b00 || period_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got pwm=%b alarm=%b tick=%b, want 00 00 0",
               pwm_out, alarm, period_tick);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push(11, 0, 0, 2'b00);
    push(10, 4, 0, 2'b00);
    wait_tick(); wait_tick();
    repeat (3) @(negedge clk);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_records: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
